// File: rtl/ro_measure_ctrl.sv
// Ring-oscillator measurement sequencer: selects an oscillator, gates the edge
// counter for a fixed window, waits for resync, then captures the count.
module ro_measure_ctrl #(
  parameter int NUM_RO        = 4,
  parameter int SEL_W         = 2,
  parameter int CNT_W         = 16,
  parameter int SETTLE_CYCLES = 8,
  parameter int GATE_CYCLES   = 1000,
  parameter int SYNC_CYCLES   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             scan,
  input  logic [SEL_W-1:0] ro_idx,
  input  logic             abort,
  input  logic [CNT_W-1:0] cnt_value,
  input  logic             cnt_ovf,
  output logic [SEL_W-1:0] ro_sel,
  output logic             ro_en,
  output logic             cnt_clear,
  output logic             cnt_enable,
  output logic [CNT_W-1:0] result,
  output logic [SEL_W-1:0] result_idx,
  output logic             result_ovf,
  output logic             result_valid,
  output logic             busy,
  output logic             done
);

  // state   | meaning
  // IDLE    | waiting for start
  // SETTLE  | oscillator running, counter cleared, gate closed
  // GATE    | counter gated on for GATE_CYCLES
  // DRAIN   | gate closed, waiting for counter resync
  // CAPTURE | latch count; next oscillator or finish
  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] SETTLE  = 3'd1;
  localparam logic [2:0] GATE    = 3'd2;
  localparam logic [2:0] DRAIN   = 3'd3;
  localparam logic [2:0] CAPTURE = 3'd4;

  localparam int TMAX_A = (SETTLE_CYCLES > GATE_CYCLES) ? SETTLE_CYCLES : GATE_CYCLES;
  localparam int TMAX   = (TMAX_A > SYNC_CYCLES) ? TMAX_A : SYNC_CYCLES;
  localparam int TW     = $clog2(TMAX + 1);

  localparam logic [TW-1:0]    T_SETTLE = TW'(SETTLE_CYCLES);
  localparam logic [TW-1:0]    T_GATE   = TW'(GATE_CYCLES);
  localparam logic [TW-1:0]    T_SYNC   = TW'(SYNC_CYCLES);
  localparam logic [TW-1:0]    T_ONE    = TW'(1);
  localparam logic [SEL_W-1:0] LAST_RO  = SEL_W'(NUM_RO - 1);

  logic [2:0]    state;
  logic [TW-1:0] timer;
  logic          scan_q;
  logic          timer_tc;
  logic          abortable;

  assign timer_tc   = (timer == T_ONE);
  assign abortable  = (state == SETTLE) || (state == GATE) || (state == DRAIN);
  assign busy       = (state != IDLE);
  assign ro_en      = (state != IDLE);
  assign cnt_enable = (state == GATE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      timer        <= '0;
      scan_q       <= 1'b0;
      ro_sel       <= '0;
      cnt_clear    <= 1'b0;
      result       <= '0;
      result_idx   <= '0;
      result_ovf   <= 1'b0;
      result_valid <= 1'b0;
      done         <= 1'b0;
    end else begin
      cnt_clear    <= 1'b0;
      result_valid <= 1'b0;
      done         <= 1'b0;
      if (abort && abortable) begin
        state <= IDLE;
        done  <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              scan_q    <= scan;
              if (scan)
                ro_sel <= '0;
              else if (ro_idx > LAST_RO)
                ro_sel <= LAST_RO;
              else
                ro_sel <= ro_idx;
              timer     <= T_SETTLE;
              cnt_clear <= 1'b1;
              state     <= SETTLE;
            end
          end
          SETTLE: begin
            if (timer_tc) begin
              timer <= T_GATE;
              state <= GATE;
            end else begin
              timer <= timer - T_ONE;
            end
          end
          GATE: begin
            if (timer_tc) begin
              timer <= T_SYNC;
              state <= DRAIN;
            end else begin
              timer <= timer - T_ONE;
            end
          end
          DRAIN: begin
            if (timer_tc)
              state <= CAPTURE;
            else
              timer <= timer - T_ONE;
          end
          CAPTURE: begin
            result       <= cnt_value;
            result_ovf   <= cnt_ovf;
            result_idx   <= ro_sel;
            result_valid <= 1'b1;
            // abort here lets the capture finish but stops the scan
            if (scan_q && (ro_sel < LAST_RO) && !abort) begin
              ro_sel    <= ro_sel + SEL_W'(1);
              timer     <= T_SETTLE;
              cnt_clear <= 1'b1;
              state     <= SETTLE;
            end else begin
              state <= IDLE;
              done  <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ro_measure_ctrl.sv
// Directed bench for ro_measure_ctrl with a behavioural edge-counter model.
module tb_ro_measure_ctrl;

  localparam int SEL_W = 3;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             start, scan, abort;
  logic [SEL_W-1:0] ro_idx;
  logic [CNT_W-1:0] cnt_value;
  logic             cnt_ovf;
  logic [SEL_W-1:0] ro_sel;
  logic             ro_en, cnt_clear, cnt_enable;
  logic [CNT_W-1:0] result;
  logic [SEL_W-1:0] result_idx;
  logic             result_ovf, result_valid, busy, done;

  logic [CNT_W-1:0] rate [8];
  int checks = 0;
  int errors = 0;

  ro_measure_ctrl #(
    .NUM_RO(4), .SEL_W(SEL_W), .CNT_W(CNT_W),
    .SETTLE_CYCLES(8), .GATE_CYCLES(1000), .SYNC_CYCLES(4)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .scan(scan), .ro_idx(ro_idx),
    .abort(abort), .cnt_value(cnt_value), .cnt_ovf(cnt_ovf), .ro_sel(ro_sel),
    .ro_en(ro_en), .cnt_clear(cnt_clear), .cnt_enable(cnt_enable),
    .result(result), .result_idx(result_idx), .result_ovf(result_ovf),
    .result_valid(result_valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // edge counter: adds rate[ro_sel] per gated clk, sticky wrap flag
  initial begin
    cnt_value = '0;
    cnt_ovf   = 1'b0;
  end
  always @(posedge clk) begin
    if (cnt_clear) begin
      cnt_value <= '0;
      cnt_ovf   <= 1'b0;
    end else if (cnt_enable) begin
      cnt_value <= cnt_value + rate[ro_sel];
      if ({1'b0, cnt_value} + {1'b0, rate[ro_sel]} > 17'h0FFFF) cnt_ovf <= 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_ro_en"}, ro_en, 0);
    chk({tag, "_cnt_en"}, cnt_enable, 0);
    chk({tag, "_cnt_clr"}, cnt_clear, 0);
    chk({tag, "_ro_sel"}, ro_sel, 0);
    chk({tag, "_result"}, result, 0);
    chk({tag, "_res_idx"}, result_idx, 0);
    chk({tag, "_res_ovf"}, result_ovf, 0);
    chk({tag, "_valid"}, result_valid, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  // single run; n counts cycles after the start cycle (start = cycle 0)
  task automatic run_single(input logic [SEL_W-1:0] idx, input int exp_res, input int exp_idx,
                            input logic exp_ovf, input logic with_abort, input logic busy_start);
    int  n;
    bit  seen;
    @(negedge clk);
    start = 1'b1; scan = 1'b0; ro_idx = idx; abort = with_abort;
    n = 0; seen = 0;
    while (!seen && n < 3000) begin
      @(negedge clk);
      start = 1'b0; abort = 1'b0; n++;
      if (busy_start && n == 100) begin
        start = 1'b1; scan = 1'b1; ro_idx = '0;
      end
      if (n == 1) begin
        chk("clear_first", cnt_clear, 1);
        chk("busy_run", busy, 1);
        chk("ro_sel", ro_sel, exp_idx);
      end
      if (n == 2)    chk("clear_once", cnt_clear, 0);
      if (n == 8)    chk("settle_last", cnt_enable, 0);
      if (n == 9)    chk("gate_open", cnt_enable, 1);
      if (n == 1008) chk("gate_last", cnt_enable, 1);
      if (n == 1009) chk("gate_closed", cnt_enable, 0);
      if (n == 1013) chk("ro_sel_hold", ro_sel, exp_idx);
      if (result_valid) seen = 1;
    end
    chk("latency", n, 1014);
    chk("result", result, exp_res);
    chk("result_idx", result_idx, exp_idx);
    chk("result_ovf", result_ovf, exp_ovf);
    chk("done_with_valid", done, 1);
    chk("idle_after", busy, 0);
    @(negedge clk);
    chk("valid_pulse", result_valid, 0);
    chk("done_pulse", done, 0);
    chk("result_hold", result, exp_res);
  endtask

  initial begin
    int n, k;
    bit any_valid;
    for (int i = 0; i < 8; i++) rate[i] = '0;
    reset = 1'b0; start = 1'b0; scan = 1'b0; abort = 1'b0; ro_idx = '0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    reset = 1'b1;

    // 1: single, ro 2 at 3/clk
    rate[2] = 16'd3;
    run_single(3'd2, 3000, 2, 1'b0, 1'b0, 1'b0);

    // 2: scan, rates 1..4
    rate[0] = 16'd1; rate[1] = 16'd2; rate[2] = 16'd3; rate[3] = 16'd4;
    @(negedge clk);
    start = 1'b1; scan = 1'b1; ro_idx = 3'd2;
    n = 0; k = 0;
    while (k < 4 && n < 6000) begin
      @(negedge clk);
      start = 1'b0; n++;
      if (result_valid) begin
        chk("scan_result", result, 1000 * (k + 1));
        chk("scan_idx", result_idx, k);
        chk("scan_done", done, (k == 3) ? 1 : 0);
        k++;
      end
    end
    chk("scan_count", k, 4);
    chk("scan_idle", busy, 0);

    // 3: overflow at 70/clk on ro 1
    rate[1] = 16'd70;
    run_single(3'd1, 4464, 1, 1'b1, 1'b0, 1'b0);

    // 4: abort in GATE at cycle 500
    @(negedge clk);
    start = 1'b1; scan = 1'b0; ro_idx = 3'd0;
    for (int i = 1; i <= 500; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("abort_in_gate", cnt_enable, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_cnt_en", cnt_enable, 0);
    chk("abort_ro_en", ro_en, 0);
    chk("abort_done", done, 1);
    chk("abort_valid", result_valid, 0);
    any_valid = 0;
    repeat (1100) begin
      @(negedge clk);
      if (result_valid || busy) any_valid = 1;
    end
    chk("abort_quiet", any_valid, 0);

    // 5: ro_idx=7 clamps to 3; start while busy ignored
    rate[3] = 16'd4;
    run_single(3'd7, 4000, 3, 1'b0, 1'b0, 1'b1);

    // 6: reset in DRAIN, then start+abort together from IDLE
    @(negedge clk);
    start = 1'b1; scan = 1'b0; ro_idx = 3'd2;
    for (int i = 1; i <= 1010; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    reset = 1'b0;
    #1;
    chk_all_zero("rst_drain");
    @(negedge clk);
    reset = 1'b1;
    rate[1] = 16'd2;
    run_single(3'd1, 2000, 1, 1'b0, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
